// File: rtl/instr_decode_stage.sv
// Decode stage: latches IR, sequences register-file operand reads, holds a decoded bundle; DECODE_ILLEGAL_TRAP_EN flags illegal encodings.
// Latency 1 + RD cycles from accept to out_valid; bundle held while out_ready is low, in_ready only in IDLE or a retiring ISSUE.
module instr_decode_stage #(
  parameter int DATA_W   = 16,
  parameter int REG_W    = 3,
  parameter int RD_PORTS = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_instr,
  output logic              rd_en0,
  output logic [REG_W-1:0]  rd_num0,
  output logic              rd_en1,
  output logic [REG_W-1:0]  rd_num1,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2:0]        opcode,
  output logic [1:0]        op,
  output logic [2:0]        cond,
  output logic [1:0]        alu_op,
  output logic [1:0]        shift,
  output logic [DATA_W-1:0] sximm5,
  output logic [DATA_W-1:0] sximm8,
  output logic [8:0]        sxim9,
  output logic [REG_W-1:0]  wr_num,
  output logic              wr_en,
  output logic              out_illegal
);

  typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, ISSUE = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [15:0] ir_q;
  logic        rd_cnt_q, rd_cnt_d;
  logic        accept, rd_last;
  logic [1:0]  nops_in, nops_ir;
  logic [5:0]  regs_ir;
  logic [3:0]  wr_ir;

  function automatic logic is_illegal(input logic [15:0] w);
    logic [1:0] o;
    o = w[12:11];
    case (w[15:13])
      3'b000:  is_illegal = 1'b1;
      3'b001:  is_illegal = (w[10:8] > 3'd4);
      3'b010:  is_illegal = (o == 2'b01);
      3'b110:  is_illegal = o[0];
      3'b111:  is_illegal = (o != 2'b00);
      default: is_illegal = 1'b0;
    endcase
  endfunction

  // Illegal encodings read nothing, so they go straight to ISSUE.
  function automatic logic [1:0] n_operands(input logic [15:0] w);
    n_operands = 2'd0;
    if (!is_illegal(w)) begin
      case (w[15:13])
        3'b110:  n_operands = (w[12:11] == 2'b00) ? 2'd1 : 2'd0;
        3'b101:  n_operands = (w[12:11] == 2'b11) ? 2'd1 : 2'd2;
        3'b011:  n_operands = 2'd1;
        3'b100:  n_operands = 2'd2;
        3'b010:  n_operands = w[11] ? 2'd0 : 2'd1;
        default: n_operands = 2'd0;
      endcase
    end
  endfunction

  // {first, second} operand in issue order
  function automatic logic [5:0] operand_regs(input logic [15:0] w);
    case (w[15:13])
      3'b110:  operand_regs = {w[2:0], 3'd0};
      3'b101:  operand_regs = (w[12:11] == 2'b11) ? {w[2:0], 3'd0} : {w[10:8], w[2:0]};
      3'b011:  operand_regs = {w[10:8], 3'd0};
      3'b100:  operand_regs = {w[10:8], w[7:5]};
      3'b010:  operand_regs = {w[7:5], 3'd0};
      default: operand_regs = 6'd0;
    endcase
  endfunction

  // {wr_en, wr_num}
  function automatic logic [3:0] write_target(input logic [15:0] w);
    write_target = {1'b0, w[7:5]};
    if (!is_illegal(w)) begin
      case (w[15:13])
        3'b110:  write_target = (w[12:11] == 2'b10) ? {1'b1, w[10:8]} : {1'b1, w[7:5]};
        3'b101:  write_target[3] = (w[12:11] != 2'b01);
        3'b011:  write_target[3] = 1'b1;
        3'b010:  if (w[12]) write_target = {1'b1, 3'd7};
        default: write_target = {1'b0, w[7:5]};
      endcase
    end
  endfunction

  assign nops_in = n_operands(in_instr);
  assign nops_ir = n_operands(ir_q);
  assign regs_ir = operand_regs(ir_q);
  assign wr_ir   = write_target(ir_q);
  assign accept  = in_valid & in_ready;
  assign rd_last = (RD_PORTS == 2) || rd_cnt_q || (nops_ir == 2'd1);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      ir_q     <= '0;
      rd_cnt_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_cnt_q <= rd_cnt_d;
      if (accept) ir_q <= in_instr;
    end
  end

  always_comb begin
    state_d  = state_q;
    rd_cnt_d = 1'b0;
    case (state_q)
      IDLE, ISSUE: begin
        if (accept)
          state_d = (nops_in == 2'd0) ? ISSUE : RD;
        else if (state_q == ISSUE && out_ready)
          state_d = IDLE;
      end
      RD: begin
        if (rd_last) state_d = ISSUE;
        else         rd_cnt_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = reset_n & ((state_q == IDLE) | (state_q == ISSUE & out_ready));
    out_valid = (state_q == ISSUE);
    rd_en0    = 1'b0;
    rd_num0   = '0;
    rd_en1    = 1'b0;
    rd_num1   = '0;
    if (state_q == RD) begin
      rd_en0  = 1'b1;
      rd_num0 = REG_W'((RD_PORTS == 1 && rd_cnt_q) ? regs_ir[2:0] : regs_ir[5:3]);
      if (RD_PORTS == 2 && nops_ir == 2'd2) begin
        rd_en1  = 1'b1;
        rd_num1 = REG_W'(regs_ir[2:0]);
      end
    end
  end

  assign opcode = ir_q[15:13];
  assign op     = ir_q[12:11];
  assign cond   = ir_q[10:8];
  assign alu_op = (opcode == 3'b011 || opcode == 3'b100 || (opcode == 3'b010 && op == 2'b10))
                  ? 2'b00 : op;
  assign shift  = (opcode inside {3'b001, 3'b010, 3'b011, 3'b100}) ? 2'b00 : ir_q[4:3];
  assign sximm5 = {{(DATA_W-5){ir_q[4]}}, ir_q[4:0]};
  assign sximm8 = {{(DATA_W-8){ir_q[7]}}, ir_q[7:0]};
  assign sxim9  = {ir_q[7], ir_q[7:0]};
  assign wr_en  = wr_ir[3];
  assign wr_num = REG_W'(wr_ir[2:0]);

`ifdef DECODE_ILLEGAL_TRAP_EN
  assign out_illegal = out_valid & is_illegal(ir_q);
`else
  assign out_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_instr_decode_stage.sv
// Random and directed checks of instr_decode_stage with one and two read ports against a table-level model.
module tb_instr_decode_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  in_valid, out_ready;
  logic [15:0] in_instr [2];
  wire  [1:0]  in_ready, rd_en0, rd_en1, out_valid, wr_en, out_illegal;
  wire  [2:0]  rd_num0 [2];
  wire  [2:0]  rd_num1 [2];
  wire  [2:0]  opcode [2];
  wire  [2:0]  cond [2];
  wire  [2:0]  wr_num [2];
  wire  [1:0]  op [2];
  wire  [1:0]  alu_op [2];
  wire  [1:0]  shift [2];
  wire  [15:0] sximm5 [2];
  wire  [15:0] sximm8 [2];
  wire  [8:0]  sxim9 [2];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  instr_decode_stage #(.DATA_W(16), .REG_W(3), .RD_PORTS(1)) dut_p1 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_instr(in_instr[0]), .rd_en0(rd_en0[0]), .rd_num0(rd_num0[0]), .rd_en1(rd_en1[0]),
    .rd_num1(rd_num1[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .opcode(opcode[0]), .op(op[0]), .cond(cond[0]), .alu_op(alu_op[0]), .shift(shift[0]),
    .sximm5(sximm5[0]), .sximm8(sximm8[0]), .sxim9(sxim9[0]), .wr_num(wr_num[0]),
    .wr_en(wr_en[0]), .out_illegal(out_illegal[0])
  );

  instr_decode_stage #(.DATA_W(16), .REG_W(3), .RD_PORTS(2)) dut_p2 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_instr(in_instr[1]), .rd_en0(rd_en0[1]), .rd_num0(rd_num0[1]), .rd_en1(rd_en1[1]),
    .rd_num1(rd_num1[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .opcode(opcode[1]), .op(op[1]), .cond(cond[1]), .alu_op(alu_op[1]), .shift(shift[1]),
    .sximm5(sximm5[1]), .sximm8(sximm8[1]), .sxim9(sxim9[1]), .wr_num(wr_num[1]),
    .wr_en(wr_en[1]), .out_illegal(out_illegal[1])
  );

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // Class table: operand list in issue order and write target.
  function automatic void ref_decode(input logic [15:0] w, output int n, output int r0,
                                     output int r1, output bit wen, output int wnum,
                                     output bit ill);
    int opc, o, rn, rd, rm;
    opc = w[15:13]; o = w[12:11]; rn = w[10:8]; rd = w[7:5]; rm = w[2:0];
    ill = (opc == 0) || (opc == 7 && o != 0) || (opc == 6 && (o == 1 || o == 3)) ||
          (opc == 2 && o == 1) || (opc == 1 && rn > 4);
    n = 0; r0 = 0; r1 = 0; wen = 0; wnum = rd;
    if (!ill) begin
      case (opc)
        6: if (o == 2) begin wen = 1; wnum = rn; end
           else begin n = 1; r0 = rm; wen = 1; end
        5: begin
             if (o == 3) begin n = 1; r0 = rm; end
             else begin n = 2; r0 = rn; r1 = rm; end
             wen = (o != 1);
           end
        3: begin n = 1; r0 = rn; wen = 1; end
        4: begin n = 2; r0 = rn; r1 = rd; end
        2: begin
             if (o != 3) begin n = 1; r0 = rd; end
             if (o != 0) begin wen = 1; wnum = 7; end
           end
        default: ;
      endcase
    end
  endfunction

  function automatic logic [63:0] exp_bundle(input logic [15:0] w);
    int n, r0, r1, wnum, opc, o, v5, v8;
    bit wen, ill;
    logic [1:0] alu, sh;
    logic [15:0] e5, e8;
    logic [8:0] e9;
    logic [2:0] wn;
    ref_decode(w, n, r0, r1, wen, wnum, ill);
    opc = w[15:13]; o = w[12:11];
    alu = (opc == 3 || opc == 4 || (opc == 2 && o == 2)) ? 2'b00 : w[12:11];
    sh  = (opc >= 1 && opc <= 4) ? 2'b00 : w[4:3];
    v5 = w[4:0]; if (v5 >= 16) v5 -= 32;
    v8 = w[7:0]; if (v8 >= 128) v8 -= 256;
    e5 = 16'(v5); e8 = 16'(v8); e9 = 9'(v8);
    wn = wen ? 3'(wnum) : 3'd0;
`ifndef DECODE_ILLEGAL_TRAP_EN
    ill = 0;
`endif
    return {6'b0, w[15:13], w[12:11], w[10:8], alu, sh, e5, e8, e9, wen, wn, ill};
  endfunction

  function automatic logic [63:0] obs_bundle(input int p);
    return {6'b0, opcode[p], op[p], cond[p], alu_op[p], shift[p], sximm5[p], sximm8[p],
            sxim9[p], wr_en[p], wr_en[p] ? wr_num[p] : 3'd0, out_illegal[p]};
  endfunction

  function automatic logic [127:0] all_outs(input int p);
    return {in_ready[p], out_valid[p], rd_en0[p], rd_num0[p], rd_en1[p], rd_num1[p],
            opcode[p], op[p], cond[p], alu_op[p], shift[p], sximm5[p], sximm8[p], sxim9[p],
            wr_num[p], wr_en[p], out_illegal[p]};
  endfunction

  // Accept one instruction (retiring any held bundle on the same edge), check reads,
  // latency and bundle, then stall for 'hold' cycles with a competing in_valid.
  task automatic run_txn(input int p, input logic [15:0] w, input int hold);
    int n, r0, r1, wnum, cyc;
    bit wen, ill;
    logic [7:0] exp_b[$];
    logic [7:0] obs_b[$];
    logic [63:0] eb;
    ref_decode(w, n, r0, r1, wen, wnum, ill);
    eb = exp_bundle(w);
    if (p == 0) begin
      if (n >= 1) exp_b.push_back({1'b1, 3'(r0), 4'b0});
      if (n == 2) exp_b.push_back({1'b1, 3'(r1), 4'b0});
    end else if (n > 0) begin
      exp_b.push_back({1'b1, 3'(r0), (n == 2), (n == 2) ? 3'(r1) : 3'd0});
    end
    @(negedge clk);
    in_instr[p] = w; in_valid[p] = 1'b1; out_ready[p] = 1'b1;
    #1 check_val("accept_rdy", in_ready[p], 1);
    @(negedge clk);
    in_valid[p] = 1'b0; out_ready[p] = 1'b0;
    #1 cyc = 1;
    while (out_valid[p] !== 1'b1 && cyc < 8) begin
      obs_b.push_back({rd_en0[p], rd_en0[p] ? rd_num0[p] : 3'd0,
                       rd_en1[p], rd_en1[p] ? rd_num1[p] : 3'd0});
      @(negedge clk);
      #1 cyc++;
    end
    check_val("latency", cyc, 1 + exp_b.size());
    check_val("rd_beats", obs_b.size(), exp_b.size());
    for (int i = 0; i < exp_b.size() && i < obs_b.size(); i++)
      check_val("rd_beat", obs_b[i], exp_b[i]);
    check_val("rd_off_in_issue", {rd_en0[p], rd_en1[p]}, 0);
    check_val("bundle", obs_bundle(p), eb);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      in_valid[p] = 1'b1; in_instr[p] = 16'($urandom);
      #1 check_val("stall_no_rdy", in_ready[p], 0);
      check_val("held", {out_valid[p], obs_bundle(p)}, {1'b1, eb});
    end
  endtask

  task automatic retire(input int p);
    @(negedge clk);
    in_valid[p] = 1'b0; out_ready[p] = 1'b1;
    #1 check_val("retire_rdy", in_ready[p], 1);
    @(negedge clk);
    out_ready[p] = 1'b0;
    #1 check_val("valid_drop", out_valid[p], 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    in_valid = 2'b11; out_ready = 2'b00;
    in_instr[0] = 16'hD2F0; in_instr[1] = 16'hD2F0;
    repeat (2) begin
      @(negedge clk);
      #1 for (int p = 0; p < 2; p++) check_val("reset_outs", all_outs(p), 0);
    end
    reset_n = 1'b1; in_valid = 2'b00;
    #1 for (int p = 0; p < 2; p++) check_val("post_reset_rdy", in_ready[p], 1);
    @(negedge clk);
    #1 for (int p = 0; p < 2; p++) check_val("no_accept_in_reset", out_valid[p], 0);

    run_txn(0, 16'hA122, 0);    // ADD R1,R1,R2
    run_txn(0, 16'hD2F0, 5);    // MOV R2,#-16, long stall
    run_txn(0, 16'h6A40, 0);    // LDR accepted on the retire edge
    retire(0);
    run_txn(1, 16'h83A0, 1);    // STR Rn=3 Rd=5, both reads in one cycle
    retire(1);
    for (int p = 0; p < 2; p++) begin
      run_txn(p, 16'h0000, 0);
      retire(p);
    end

    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < 80; k++) begin
        run_txn(p, 16'($urandom), $urandom_range(0, 3));
        if ($urandom_range(0, 2) == 0) retire(p);
      end
      retire(p);
    end

    // reset while the first operand read is in flight
    @(negedge clk);
    in_instr[0] = 16'hA122; in_valid[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    #1 check_val("midrd_rd", rd_en0[0], 1);
    reset_n = 1'b0;
    @(negedge clk);
    #1 check_val("midrd_reset_outs", all_outs(0), 0);
    reset_n = 1'b1;
    #1 check_val("midrd_rdy", in_ready[0], 1);
    @(negedge clk);
    #1 check_val("midrd_idle", {out_valid[0], rd_en0[0]}, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
